// File: rtl/scan_mux_pkg.sv
// Shared types for the scan multiplexer: FSM state encoding
// and the select/index width helper used by the top and the dwell counter.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_multiplexer_dwell_counter.sv
// Dwell counter: counts scan cycles on one channel and flags the last one.
// Ports: clk, rst (async, active-high), clear, inc -> terminal (count == DWELL-1 while inc).
module dwell_counter
    import scan_mux_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    localparam int CW = sel_width(DWELL);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_end;

    assign at_end   = (cnt_q == CW'(DWELL - 1));
    assign terminal = inc && !clear && at_end;

    // Wraps back to zero on its own after the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_multiplexer.sv
// Registered N-channel mux with manual select and round-robin scan modes.
// Ports: clk, rst (async, active-high), en, mode (0 manual / 1 scan), sel,
//   a (packed channels), [mask when SCAN_MUX_MASK_EN] -> x, ch, valid, wrap.
// Build option: define SCAN_MUX_MASK_EN to add the per-channel scan mask port.
module scan_multiplexer
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 4,
    localparam int SELW     = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
`ifdef SCAN_MUX_MASK_EN
    input  logic [CHANNELS-1:0]       mask,
`endif
    input  logic [CHANNELS*WIDTH-1:0] a,
    output logic [WIDTH-1:0]          x,
    output logic [SELW-1:0]           ch,
    output logic                      valid,
    output logic                      wrap
);

    state_e            state_q;
    state_e            state_d;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  x_d;
    logic [SELW-1:0]   ch_q;
    logic [SELW-1:0]   ch_d;
    logic              valid_q;
    logic              valid_d;
    logic              wrap_q;
    logic              wrap_d;

    logic              cnt_clr;
    logic              cnt_inc;
    logic              term;

    logic [CHANNELS-1:0] mask_w;
    logic              any_en;
    logic              hi_found;
    logic [SELW-1:0]   hi_ch;
    logic              ge_found;
    logic [SELW-1:0]   ge_ch;
    logic [SELW-1:0]   low_ch;
    logic [SELW-1:0]   nxt_ch;
    logic [SELW-1:0]   start_ch;

`ifdef SCAN_MUX_MASK_EN
    assign mask_w = mask;
`else
    assign mask_w = '1;
`endif

    function automatic logic [WIDTH-1:0] pick(
        input logic [CHANNELS*WIDTH-1:0] bus,
        input logic [SELW-1:0]           idx
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SELW'(k)) begin
                r = bus[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clr),
        .inc      (cnt_inc),
        .terminal (term)
    );

    // Channel search over the enabled set. Descending scan so the last
    // hit is the lowest index: hi_ch is the first enabled channel above
    // ch_q, ge_ch the first at or above it, low_ch the lowest overall.
    always_comb begin
        any_en   = 1'b0;
        hi_found = 1'b0;
        ge_found = 1'b0;
        hi_ch    = '0;
        ge_ch    = '0;
        low_ch   = '0;
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (mask_w[j]) begin
                any_en = 1'b1;
                low_ch = SELW'(j);
                if (SELW'(j) > ch_q) begin
                    hi_found = 1'b1;
                    hi_ch    = SELW'(j);
                end
                if (SELW'(j) >= ch_q) begin
                    ge_found = 1'b1;
                    ge_ch    = SELW'(j);
                end
            end
        end
        nxt_ch   = hi_found ? hi_ch : low_ch;
        start_ch = ge_found ? ge_ch : low_ch;
    end

    always_comb begin
        state_d = ST_IDLE;
        x_d     = x_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        unique case (1'b1)
            !en: begin
                state_d = ST_IDLE;
            end
            en && !mode: begin
                state_d = ST_MANUAL;
                if (int'(sel) < CHANNELS) begin
                    ch_d    = sel;
                    x_d     = pick(a, sel);
                    valid_d = 1'b1;
                end
            end
            en && mode: begin
                state_d = ST_SCAN;
                if (!any_en) begin
                    ch_d = ch_q;
                end else if (state_q != ST_SCAN) begin
                    // Fresh scan: stay on the current channel (or the
                    // next enabled one) with the dwell count restarted.
                    ch_d    = start_ch;
                    x_d     = pick(a, start_ch);
                    valid_d = 1'b1;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                    valid_d = 1'b1;
                    if (term) begin
                        ch_d   = nxt_ch;
                        wrap_d = !hi_found;
                    end
                    x_d = pick(a, ch_d);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign x     = x_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: doc/scan_multiplexer.md
# scan_multiplexer

Registered N-channel, W-bit multiplexer with a manual select mode and an automatic round-robin scan mode that dwells a programmable number of cycles on each channel. Generalises the 2:1 combinational multiplexer to parametrised width and channel count, with a clocked output, channel index, valid flag and scan wrap pulse. Sits between parallel data sources (switch banks, sensor registers) and a single downstream consumer such as a display driver or serial transmitter.

## Interface
- WIDTH, 8, bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥1)
- DWELL, 4, cycles spent on each channel in scan mode (≥1)
- SELW, derived = max(1, clog2(CHANNELS)), select/index width
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  block enable
- mode  input  1  0 = manual select, 1 = auto scan
- sel  input  SELW  manual channel select
- a  input  CHANNELS*WIDTH  packed inputs; channel k = a[k*WIDTH +: WIDTH]
- x  output  WIDTH  registered selected data
- ch  output  SELW  channel currently driven on x
- valid  output  1  x holds live data of channel ch
- wrap  output  1  one-cycle pulse when scan returns from last channel to channel 0

## Operation
- States: IDLE, MANUAL, SCAN, evaluated every clock edge from en/mode: en=0 → IDLE; en=1, mode=0 → MANUAL; en=1, mode=1 → SCAN.
- Reset (asynchronous): x=0, ch=0, valid=0, wrap=0, dwell counter=0, state IDLE.
- IDLE: x and ch hold; valid=0; wrap=0; dwell counter cleared.
- MANUAL: ch ← sel, x ← a[sel], valid=1. If sel ≥ CHANNELS: ch and x hold, valid=0. Dwell counter held at 0; wrap=0.
- SCAN: x ← a[ch_next] each cycle (tracks live input changes). Counter increments; when counter = DWELL-1, ch_next = ch+1 (CHANNELS-1 → 0), counter ← 0. wrap=1 in the cycle the CHANNELS-1 → 0 transition is registered.
- Entering SCAN from IDLE or MANUAL: scan starts at the current ch with counter 0; previous dwell progress is discarded.
- DWELL=1: advance every cycle. CHANNELS=1: ch stays 0; wrap pulses every DWELL cycles.
- en deasserted mid-dwell: next edge enters IDLE, counter cleared, ch retained.

## Timing
- One-cycle latency: x, ch, valid, wrap all update on the same rising edge; x always equals a[ch] as sampled at that edge.
- valid rises on the first edge after entering MANUAL/SCAN; falls on the first edge in IDLE.
- Each channel occupies exactly DWELL consecutive cycles in continuous SCAN; full scan period = CHANNELS*DWELL cycles.
- Mode change takes effect on the next edge; no mode-change dead cycle.

## Configuration
- SCAN_MUX_MASK_EN defined: extra port mask input CHANNELS (1 = channel included). SCAN skips channels whose mask bit is 0, advancing to the next enabled index (with wrap; wrap pulses when the index numerically decreases). If the current channel becomes masked, it advances at the end of its dwell. All bits 0: ch and x hold, valid=0. MANUAL ignores mask.
- Not defined: no mask port; all channels scanned in order.

## Structure
- Package scan_mux_pkg: state encoding (IDLE, MANUAL, SCAN) typedef and the SELW width function.
- One sub-module: dwell_counter (parameter DWELL; inputs clk, rst, clear, inc; output terminal pulse at DWELL-1, self-clearing).
- Top holds state register, channel index, next-channel/mask logic and output registers.

## Test plan
Bench defaults: WIDTH=8, CHANNELS=4, DWELL=3, a = {8'hDD, 8'hCC, 8'hBB, 8'hAA} (ch0=AA).
- Reset asserted mid-scan, between edges → x=00, ch=0, valid=0, wrap=0 immediately, without a clock edge.
- en=1, mode=0, sel=2 → next edge x=CC, ch=2, valid=1; sel=3 → next edge x=DD.
- en=1, mode=1 from ch=0 → x sequence AA×3, BB×3, CC×3, DD×3, AA; wrap=1 only on the first AA cycle after DD.
- SCAN on ch1, a[ch1] changes BB→5A mid-dwell → x=5A next edge, ch still 1, dwell length unchanged.
- Mode switch SCAN→MANUAL (sel=0) on 2nd dwell cycle of ch2, then back to SCAN → x=AA in manual, then scan resumes at ch0 for a full 3 cycles.
- With SCAN_MUX_MASK_EN, mask=4'b1010 → scan sequence BB×3, DD×3, BB (wrap=1); mask=0 → valid=0, x holds.
